pll_lock_reset_seq: RTL and testbench

//   Sits directly downstream of the WiMax PLL wrapper and consumes its lock indication.
//   - Synchronises the PLL 'locked' flag and requires it to stay high for a qualification window.
//   - Releases per-stage synchronous resets for the baseband pipeline in a fixed staggered order.
//   - Re-asserts all stage resets and counts the event on every loss of lock.
//   - Optionally requests a PLL reset when lock is never achieved.

---
 rtl/pll_lock_reset_seq.sv | 171 +++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_seq.sv
// pll_lock_reset_seq: qualifies the PLL lock flag and releases the baseband stage resets
// in a fixed staggered order. Any loss of lock after qualification re-asserts every stage
// reset and is counted in a saturating counter.
// Optional feature macro: PLL_LOCK_TIMEOUT_EN. When defined, a PLL reset request is pulsed
// if lock is not seen within LOCK_TIMEOUT cycles of waiting. When undefined, pll_rst_req is 0.
module pll_lock_reset_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned NUM_STAGES         = 4,
    parameter int unsigned STAGE_GAP          = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned PLL_RST_CYCLES     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic [NUM_STAGES-1:0] stage_rst_out,
    output logic                  sys_ready,
    output logic [7:0]            lock_loss_cnt,
    output logic                  pll_rst_req
);

    localparam int unsigned REL_LAST = (NUM_STAGES - 1) * STAGE_GAP;
    localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned REL_W    = $clog2(REL_LAST + 2);

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int unsigned WAIT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned PRST_W = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        StWaitLock,
        StStable,
        StRelease,
        StRun,
        StPllRst
    } state_t;

    logic [WAIT_W-1:0] wait_cnt;
    logic [PRST_W-1:0] prst_cnt;
`else
    typedef enum logic [2:0] {
        StWaitLock,
        StStable,
        StRelease,
        StRun
    } state_t;
`endif

    state_t              state;
    logic [1:0]          sync_q;
    logic                locked_s;
    logic [STABLE_W-1:0] stable_cnt;
    logic [REL_W-1:0]    rel_cnt;

    assign locked_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // Sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StWaitLock;
            stable_cnt    <= '0;
            rel_cnt       <= '0;
            stage_rst_out <= '1;
            sys_ready     <= 1'b0;
            lock_loss_cnt <= 8'd0;
`ifdef PLL_LOCK_TIMEOUT_EN
            wait_cnt      <= '0;
            prst_cnt      <= '0;
            pll_rst_req   <= 1'b0;
`endif
        end else begin
`ifdef PLL_LOCK_TIMEOUT_EN
            // Timeout counter only runs while waiting; it restarts on every entry.
            wait_cnt <= '0;
`endif
            case (state)
                StWaitLock: begin
                    stage_rst_out <= '1;
                    sys_ready     <= 1'b0;
                    if (locked_s) begin
                        state      <= StStable;
                        stable_cnt <= '0;
                    end
`ifdef PLL_LOCK_TIMEOUT_EN
                    else if (wait_cnt == WAIT_W'(LOCK_TIMEOUT - 1)) begin
                        state       <= StPllRst;
                        pll_rst_req <= 1'b1;
                        prst_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                StStable: begin
                    if (!locked_s) begin
                        // Lock dropped before qualification: not counted as a loss.
                        state      <= StWaitLock;
                        stable_cnt <= '0;
                    end else if (stable_cnt == STABLE_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state   <= StRelease;
                        rel_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end
                StRelease: begin
                    if (!locked_s) begin
                        state         <= StWaitLock;
                        stage_rst_out <= '1;
                        sys_ready     <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end else begin
                        // Bits already released stay released as rel_cnt keeps rising.
                        for (int k = 0; k < int'(NUM_STAGES); k++) begin
                            if (rel_cnt >= REL_W'(k * STAGE_GAP)) begin
                                stage_rst_out[k] <= 1'b0;
                            end
                        end
                        if (rel_cnt == REL_W'(REL_LAST)) begin
                            state <= StRun;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state         <= StWaitLock;
                        stage_rst_out <= '1;
                        sys_ready     <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end else begin
                        sys_ready <= 1'b1;
                    end
                end
`ifdef PLL_LOCK_TIMEOUT_EN
                StPllRst: begin
                    // Lock flag is ignored while the PLL is being reset.
                    if (prst_cnt == PRST_W'(PLL_RST_CYCLES - 1)) begin
                        pll_rst_req <= 1'b0;
                        state       <= StWaitLock;
                    end else begin
                        prst_cnt <= prst_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    state <= StWaitLock;
                end
            endcase
        end
    end

`ifndef PLL_LOCK_TIMEOUT_EN
    assign pll_rst_req = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// tb_pll_lock_reset_seq: randomized lock/unlock stimulus checked every cycle against a
// reference model that derives outputs from the length of the current synced-lock run.
module tb_pll_lock_reset_seq;

    localparam int LSC  = 8;
    localparam int NS   = 4;
    localparam int GAP  = 4;
    localparam int LT   = 64;
    localparam int PRC  = 4;
`ifdef PLL_LOCK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic [NS-1:0] stage_rst_out;
    logic          sys_ready;
    logic [7:0]    lock_loss_cnt;
    logic          pll_rst_req;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .LOCK_STABLE_CYCLES(LSC),
        .NUM_STAGES        (NS),
        .STAGE_GAP         (GAP),
        .LOCK_TIMEOUT      (LT),
        .PLL_RST_CYCLES    (PRC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .stage_rst_out(stage_rst_out),
        .sys_ready    (sys_ready),
        .lock_loss_cnt(lock_loss_cnt),
        .pll_rst_req  (pll_rst_req)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: samples of pll_locked still in flight through the synchroniser,
    // length of the current run of synced-locked edges, and expected loss count.
    bit q_hist[$];
    int run_len  = 0;
    int loss     = 0;
    int tmo_j    = 0;
    bit tmo_test = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs (optionally with a sub-cycle glitch), advance model, compare.
    task automatic step(input logic lk, input logic rs, input bit glitch);
        bit            seen;
        logic [NS-1:0] e_rst;
        bit            e_rdy;
        bit            e_req;
        rst        = rs;
        pll_locked = lk;
        if (glitch) begin
            #2 pll_locked = ~lk;
            #2 pll_locked = lk;
        end
        @(posedge clk);
        if (rs) begin
            q_hist.delete();
            run_len = 0;
            loss    = 0;
            tmo_j   = 0;
        end else begin
            seen = 1'b0;
            if (q_hist.size() == 2) seen = q_hist.pop_front();
            q_hist.push_back(lk);
            tmo_j++;
            if (seen) begin
                if (run_len < 1000000) run_len++;
            end else begin
                // Qualified (reached release) before the drop -> counted loss.
                if (run_len >= LSC + 1 && loss < 255) loss++;
                run_len = 0;
            end
        end
        for (int k = 0; k < NS; k++) e_rst[k] = !(run_len >= LSC + 2 + k * GAP);
        e_rdy = (run_len >= LSC + 3 + (NS - 1) * GAP);
        e_req = TMO_EN && tmo_test && (tmo_j >= LT) && (((tmo_j - LT) % (LT + PRC)) < PRC);
        #1;
        check_eq("stage_rst_out", 32'(stage_rst_out), 32'(e_rst));
        check_eq("sys_ready", 32'(sys_ready), 32'(e_rdy));
        check_eq("lock_loss_cnt", 32'(lock_loss_cnt), 32'(loss));
        check_eq("pll_rst_req", 32'(pll_rst_req), 32'(e_req));
    endtask

    initial begin
        int hi;
        int lo;
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Reset with lock low.
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check_eq("reset_stage", 32'(stage_rst_out), 32'h0000_000F);

        // Clean lock through to RUN.
        repeat (30) step(1'b1, 1'b0, 1'b0);
        check_eq("clean_ready", 32'(sys_ready), 32'd1);

        // Loss in RUN, then an early drop during qualification, then relock.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        check_eq("loss_count", 32'(lock_loss_cnt), 32'd1);
        repeat (5) step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        check_eq("early_drop_hold", 32'(stage_rst_out), 32'h0000_000F);
        repeat (30) step(1'b1, 1'b0, 1'b0);
        check_eq("early_drop_cnt", 32'(lock_loss_cnt), 32'd1);

        // Randomized lock/unlock runs with occasional glitches and resets.
        for (int i = 0; i < 60; i++) begin
            hi = $urandom_range(1, 35);
            lo = $urandom_range(1, 8);
            for (int j = 0; j < hi; j++) step(1'b1, 1'b0, ($urandom % 8) == 0);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b0, ($urandom % 8) == 0);
            if (($urandom % 10) == 0) step(1'($urandom % 2), 1'b1, 1'b0);
        end

        // Reset in the middle of the release stagger.
        repeat (2) step(1'b0, 1'b1, 1'b0);
        repeat (16) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("mid_rst_stage", 32'(stage_rst_out), 32'h0000_000F);
        check_eq("mid_rst_cnt", 32'(lock_loss_cnt), 32'd0);

        // Saturation of the loss counter.
        for (int i = 0; i < 300; i++) begin
            hi = $urandom_range(10, 15);
            for (int j = 0; j < hi; j++) step(1'b1, 1'b0, 1'b0);
            repeat (2) step(1'b0, 1'b0, 1'b0);
        end
        check_eq("saturate", 32'(lock_loss_cnt), 32'd255);

        // Lock stuck low: periodic PLL reset request (or none without the feature).
        repeat (2) step(1'b0, 1'b1, 1'b0);
        tmo_test = 1'b1;
        repeat (300) step(1'b0, 1'b0, 1'b0);
        tmo_test = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
